// File: rtl/piso_pkg.sv
// Shared types for the PISO transmitter: FSM states, per-bit cell control and counter sizing.
package piso_pkg;

  typedef enum logic {StIdle, StShift} state_e;

  typedef enum logic [1:0] {CellHold, CellLoad, CellShiftIn, CellClear} cell_ctrl_e;

  localparam int unsigned WIDTH_DEFAULT = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH_DEFAULT);

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_if.sv
// Load handshake and serial output bundle between a word source and the PISO transmitter.
interface piso_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] d_in;
  logic             load_valid;
  logic             load_ready;
  logic             hold;
  logic             s_out;
  logic             s_valid;
  logic             s_first;
  logic             s_last;

  modport master (
    output d_in, load_valid, hold,
    input  load_ready, s_out, s_valid, s_first, s_last
  );

  modport slave (
    input  d_in, load_valid, hold,
    output load_ready, s_out, s_valid, s_first, s_last
  );
endinterface

// File: rtl/piso_bit_cell.sv
// One shifter bit: flip-flop with a hold/load/shift-in/clear next-value mux.
module piso_bit_cell
  import piso_pkg::*;
(
  input  logic       clk,
  input  cell_ctrl_e ctrl,
  input  logic       load_val,
  input  logic       shift_val,
  output logic       q
);

  logic q_d;

  always_comb begin
    q_d = q;
    unique case (ctrl)
      CellHold:    q_d = q;
      CellLoad:    q_d = load_val;
      CellShiftIn: q_d = shift_val;
      CellClear:   q_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    q <= q_d;
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with valid/ready load, stall and first/last frame markers.
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic r,
  piso_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] PenultIdx = CntW'(WIDTH - 2);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  cell_ctrl_e      cell_ctrl;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shift_in;
  logic            load_ready;
  logic            accept;

  // Ready in the s_last cycle lets the next frame follow with no idle gap.
  assign load_ready = r & ((state_q == StIdle) | ((state_q == StShift) & last_q & ~bus.hold));
  assign accept     = bus.load_valid & load_ready;

  always_comb begin
    if (MSB_FIRST) begin
      shift_in = {sr[WIDTH-2:0], 1'b0};
    end else begin
      shift_in = {1'b0, sr[WIDTH-1:1]};
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    piso_bit_cell u_cell (
      .clk       (clk),
      .ctrl      (cell_ctrl),
      .load_val  (bus.d_in[i]),
      .shift_val (shift_in[i]),
      .q         (sr[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    first_d   = first_q;
    last_d    = last_q;
    cell_ctrl = CellHold;
    if (!r) begin
      cell_ctrl = CellClear;
    end else if (accept) begin
      state_d   = StShift;
      cnt_d     = '0;
      valid_d   = 1'b1;
      first_d   = 1'b1;
      last_d    = 1'b0;
      cell_ctrl = CellLoad;
    end else if ((state_q == StShift) && !bus.hold) begin
      if (last_q) begin
        state_d   = StIdle;
        cnt_d     = '0;
        valid_d   = 1'b0;
        first_d   = 1'b0;
        last_d    = 1'b0;
        cell_ctrl = CellClear;
      end else begin
        // The counter never passes WIDTH-1; the s_last path above restarts it.
        cnt_d     = cnt_q + CntW'(1);
        first_d   = 1'b0;
        last_d    = (cnt_q == PenultIdx);
        cell_ctrl = CellShiftIn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.s_out      = MSB_FIRST ? sr[WIDTH-1] : sr[0];
  assign bus.s_valid    = valid_q;
  assign bus.s_first    = first_q;
  assign bus.s_last     = last_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed scenarios plus a randomized stream against a frame model.
module tb_piso_tx;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic r;
  int   checks   = 0;
  int   failures = 0;

  piso_if #(.WIDTH(W)) bus0 ();
  piso_if #(.WIDTH(W)) bus1 ();

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .r(r), .bus(bus0));
  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .r(r), .bus(bus1));

  always #5 clk = ~clk;

  // Bit k of a frame, straight from the bit-order rule.
  function automatic logic exp_bit(input logic [W-1:0] w, input int k, input bit msb);
    return msb ? w[W-1-k] : w[k];
  endfunction

  // Observed tuple: {s_valid, s_out, s_first, s_last, load_ready}
  function automatic logic [4:0] obs0();
    return {bus0.s_valid, bus0.s_out, bus0.s_first, bus0.s_last, bus0.load_ready};
  endfunction

  function automatic logic [4:0] obs1();
    return {bus1.s_valid, bus1.s_out, bus1.s_first, bus1.s_last, bus1.load_ready};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    r = 1'b0;
    bus0.d_in = 8'hFF; bus0.load_valid = 1'b1; bus0.hold = 1'b0;
    bus1.d_in = 8'hFF; bus1.load_valid = 1'b1; bus1.hold = 1'b0;
    for (int c = 0; c < 2; c++) begin
      next_cycle(); #1;
      checks++;
      if (obs0() !== 5'b00000) begin
        failures++;
        $display("FAIL reset_msb cyc %0d (valid,out,first,last,ready): got %b want 00000", c, obs0());
      end
      checks++;
      if (obs1() !== 5'b00000) begin
        failures++;
        $display("FAIL reset_lsb cyc %0d (valid,out,first,last,ready): got %b want 00000", c, obs1());
      end
    end
    bus0.load_valid = 1'b0; bus1.load_valid = 1'b0;
    r = 1'b1;
    #1;
    checks++;
    if (obs0() !== 5'b00001) begin
      failures++;
      $display("FAIL reset_release (valid,out,first,last,ready): got %b want 00001", obs0());
    end
    next_cycle(); #1;
    checks++;
    if (obs0() !== 5'b00001) begin
      failures++;
      $display("FAIL reset_idle (valid,out,first,last,ready): got %b want 00001", obs0());
    end
  endtask

  task automatic test_single_frame();
    logic [W-1:0] w;
    logic [4:0]   e;
    w = 8'hA5;
    bus0.d_in = w; bus0.load_valid = 1'b1;
    next_cycle();
    bus0.load_valid = 1'b0; bus0.d_in = 8'h00;
    for (int k = 0; k < W; k++) begin
      #1;
      e = {1'b1, exp_bit(w, k, 1'b1), k == 0, k == W - 1, k == W - 1};
      checks++;
      if (obs0() !== e) begin
        failures++;
        $display("FAIL single_frame bit %0d (valid,out,first,last,ready): got %b want %b",
                 k, obs0(), e);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (obs0() !== 5'b00001) begin
      failures++;
      $display("FAIL single_frame_end (valid,out,first,last,ready): got %b want 00001", obs0());
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    logic [4:0]   e;
    int           j;
    bus0.d_in = 8'hA5; bus0.load_valid = 1'b1;
    next_cycle();
    bus0.d_in = 8'h3C;
    for (int k = 0; k < 2 * W; k++) begin
      #1;
      w = (k < W) ? 8'hA5 : 8'h3C;
      j = k % W;
      e = {1'b1, exp_bit(w, j, 1'b1), j == 0, j == W - 1, j == W - 1};
      checks++;
      if (obs0() !== e) begin
        failures++;
        $display("FAIL back_to_back cyc %0d (valid,out,first,last,ready): got %b want %b",
                 k, obs0(), e);
      end
      if (k == W) begin
        bus0.load_valid = 1'b0;
        bus0.d_in = 8'hFF;
      end
      next_cycle();
    end
    #1;
    checks++;
    if (obs0() !== 5'b00001) begin
      failures++;
      $display("FAIL back_to_back_end (valid,out,first,last,ready): got %b want 00001", obs0());
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] w;
    logic [4:0]   e;
    int           n;
    w = 8'hA5;
    bus0.d_in = w; bus0.load_valid = 1'b1;
    next_cycle();
    bus0.load_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      #1;
      e = {1'b1, exp_bit(w, k, 1'b1), k == 0, k == W - 1, k == W - 1};
      checks++;
      if (obs0() !== e) begin
        failures++;
        $display("FAIL hold_frame bit %0d (valid,out,first,last,ready): got %b want %b",
                 k, obs0(), e);
      end
      n = (k == 2) ? 3 : ((k == W - 1) ? 2 : 0);
      if (n > 0) begin
        bus0.hold = 1'b1;
        for (int h = 0; h < n; h++) begin
          next_cycle(); #1;
          e = {1'b1, exp_bit(w, k, 1'b1), k == 0, k == W - 1, 1'b0};
          checks++;
          if (obs0() !== e) begin
            failures++;
            $display("FAIL hold_frozen bit %0d h %0d (valid,out,first,last,ready): got %b want %b",
                     k, h, obs0(), e);
          end
        end
        bus0.hold = 1'b0;
      end
      next_cycle();
    end
    // Hold is ignored while idle.
    bus0.hold = 1'b1;
    #1;
    checks++;
    if (obs0() !== 5'b00001) begin
      failures++;
      $display("FAIL hold_idle (valid,out,first,last,ready): got %b want 00001", obs0());
    end
    w = 8'h5A;
    bus0.d_in = w; bus0.load_valid = 1'b1;
    next_cycle(); #1;
    e = {1'b1, exp_bit(w, 0, 1'b1), 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs0() !== e) begin
      failures++;
      $display("FAIL hold_load_first (valid,out,first,last,ready): got %b want %b", obs0(), e);
    end
    bus0.load_valid = 1'b0; bus0.hold = 1'b0;
    next_cycle();
    for (int k = 1; k < W; k++) begin
      #1;
      e = {1'b1, exp_bit(w, k, 1'b1), 1'b0, k == W - 1, k == W - 1};
      checks++;
      if (obs0() !== e) begin
        failures++;
        $display("FAIL hold_load_frame bit %0d (valid,out,first,last,ready): got %b want %b",
                 k, obs0(), e);
      end
      next_cycle();
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] w;
    logic [4:0]   e;
    for (int f = 0; f < 2; f++) begin
      w = (f == 0) ? 8'h01 : W'($urandom);
      bus1.d_in = w; bus1.load_valid = 1'b1;
      next_cycle();
      bus1.load_valid = 1'b0; bus1.d_in = ~w;
      for (int k = 0; k < W; k++) begin
        #1;
        e = {1'b1, exp_bit(w, k, 1'b0), k == 0, k == W - 1, k == W - 1};
        checks++;
        if (obs1() !== e) begin
          failures++;
          $display("FAIL lsb_first word %h bit %0d (valid,out,first,last,ready): got %b want %b",
                   w, k, obs1(), e);
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] w;
    logic [W-1:0] w2;
    logic [4:0]   e;
    w  = W'($urandom);
    w2 = W'($urandom);
    bus0.d_in = w; bus0.load_valid = 1'b1;
    next_cycle();
    bus0.load_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      e = {1'b1, exp_bit(w, k, 1'b1), k == 0, 1'b0, 1'b0};
      checks++;
      if (obs0() !== e) begin
        failures++;
        $display("FAIL abort_pre bit %0d (valid,out,first,last,ready): got %b want %b",
                 k, obs0(), e);
      end
      if (k < 3) next_cycle();
    end
    r = 1'b0;
    bus0.load_valid = 1'b1; bus0.d_in = ~w;
    next_cycle(); #1;
    checks++;
    if (obs0() !== 5'b00000) begin
      failures++;
      $display("FAIL abort_reset (valid,out,first,last,ready): got %b want 00000", obs0());
    end
    r = 1'b1;
    bus0.d_in = w2;
    #1;
    checks++;
    if (obs0() !== 5'b00001) begin
      failures++;
      $display("FAIL abort_release (valid,out,first,last,ready): got %b want 00001", obs0());
    end
    next_cycle();
    bus0.load_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      #1;
      e = {1'b1, exp_bit(w2, k, 1'b1), k == 0, k == W - 1, k == W - 1};
      checks++;
      if (obs0() !== e) begin
        failures++;
        $display("FAIL abort_fresh bit %0d (valid,out,first,last,ready): got %b want %b",
                 k, obs0(), e);
      end
      next_cycle();
    end
  endtask

  task automatic test_random_stream();
    bit           busy;
    logic [W-1:0] word;
    int           idx;
    bit           lv;
    bit           hd;
    logic [W-1:0] d;
    bit           ready_e;
    logic [3:0]   e;
    logic [4:0]   o;
    busy = 1'b0; word = '0; idx = 0;
    for (int c = 0; c < 500; c++) begin
      lv = 1'($urandom_range(0, 1));
      hd = ($urandom_range(0, 3) == 0);
      d  = W'($urandom);
      bus0.load_valid = lv; bus0.hold = hd; bus0.d_in = d;
      #1;
      ready_e = !busy || (idx == W - 1 && !hd);
      checks++;
      if (bus0.load_ready !== ready_e) begin
        failures++;
        $display("FAIL random_ready cyc %0d: got %b want %b", c, bus0.load_ready, ready_e);
      end
      next_cycle();
      if (lv && ready_e) begin
        busy = 1'b1; word = d; idx = 0;
      end else if (busy && !hd) begin
        if (idx == W - 1) busy = 1'b0;
        else idx++;
      end
      o = obs0();
      checks++;
      if (busy) begin
        e = {1'b1, exp_bit(word, idx, 1'b1), idx == 0, idx == W - 1};
        if (o[4:1] !== e) begin
          failures++;
          $display("FAIL random_frame cyc %0d (valid,out,first,last): got %b want %b",
                   c, o[4:1], e);
        end
      end else if ({o[4], o[2], o[1]} !== 3'b000) begin
        failures++;
        $display("FAIL random_idle cyc %0d (valid,first,last): got %b want 000",
                 c, {o[4], o[2], o[1]});
      end
    end
    bus0.load_valid = 1'b0; bus0.hold = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_hold();
    test_lsb_first();
    test_reset_mid_frame();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
